aes_key_expander: RTL

//  Sequential AES key expansion engine for AES-128/192/256, selected per key at load time.

---
 rtl/aes_pkg.sv | 59 +++++
 rtl/aes_sbox.sv | 32 +++
 rtl/aes_subword.sv | 14 +
 rtl/aes_key_expander.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES types and constant helpers for the key expansion engine.
// Provides the key length encoding, Nk/Nr lookups, and GF(2^8) arithmetic.
package aes_pkg;

   typedef enum logic [1:0] {
      KEY_128 = 2'b00,
      KEY_192 = 2'b01,
      KEY_256 = 2'b10,
      KEY_BAD = 2'b11
   } key_len_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_GEN  = 2'b01,
      ST_DONE = 2'b10
   } exp_state_e;

   // Schedule words for the largest AES variant (AES-256: 4*(14+1)).
   localparam int AES_MAX_WORDS = 60;

   // Number of 32-bit key words for a key length; 0 for the illegal code.
   function automatic logic [3:0] aes_nk(input key_len_e len);
      case (len)
         KEY_128: return 4'd4;
         KEY_192: return 4'd6;
         KEY_256: return 4'd8;
         default: return 4'd0;
      endcase
   endfunction

   // Number of rounds (Nk + 6); 0 for the illegal code.
   function automatic logic [3:0] aes_nr(input key_len_e len);
      if (len == KEY_BAD) begin
         return 4'd0;
      end
      return aes_nk(len) + 4'd6;
   endfunction

   // Multiply by x in GF(2^8) with the AES polynomial.
   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   // General GF(2^8) multiply, shift-and-add over the bits of b.
   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] prod;
      logic [7:0] shifted;
      prod    = 8'h00;
      shifted = a;
      for (int k = 0; k < 8; k++) begin
         if (b[k]) begin
            prod = prod ^ shifted;
         end
         shifted = xtime(shifted);
      end
      return prod;
   endfunction

endpackage

// File: rtl/aes_sbox.sv
// AES S-box: multiplicative inverse in GF(2^8) followed by the affine map.
// The inverse is x^254 built from a square chain, so no lookup table is needed.
module aes_sbox
   import aes_pkg::*;
(
   input  logic [7:0] in_byte,
   output logic [7:0] out_byte
);

   logic [7:0] x2, x4, x8, x16, x32, x64, x128;
   logic [7:0] inv;

   // Inverse via x^254 = x^2*x^4*...*x^128, then affine transform with 0x63.
   always_comb begin
      x2   = gf_mul(in_byte, in_byte);
      x4   = gf_mul(x2, x2);
      x8   = gf_mul(x4, x4);
      x16  = gf_mul(x8, x8);
      x32  = gf_mul(x16, x16);
      x64  = gf_mul(x32, x32);
      x128 = gf_mul(x64, x64);
      inv  = gf_mul(gf_mul(gf_mul(x2, x4), gf_mul(x8, x16)),
                    gf_mul(gf_mul(x32, x64), x128));
      out_byte = inv
               ^ {inv[6:0], inv[7]}
               ^ {inv[5:0], inv[7:6]}
               ^ {inv[4:0], inv[7:5]}
               ^ {inv[3:0], inv[7:4]}
               ^ 8'h63;
   end

endmodule

// File: rtl/aes_subword.sv
// SubWord: applies the AES S-box to each byte of a 32-bit word. Combinational.
module aes_subword (
   input  logic [31:0] word_in,
   output logic [31:0] word_out
);

   for (genvar gi = 0; gi < 4; gi++) begin : g_sbox
      aes_sbox u_sbox (
         .in_byte  (word_in[8*gi +: 8]),
         .out_byte (word_out[8*gi +: 8])
      );
   end

endmodule

// File: rtl/aes_key_expander.sv
// Sequential AES-128/192/256 key expansion: one schedule word per cycle into
// an internal word store, with a registered 128-bit round-key read port.
module aes_key_expander
   import aes_pkg::*;
#(
   parameter int MAX_KEY_BITS = 256
)
(
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    key_valid_i,
   output logic                    key_ready_o,
   input  logic [1:0]              key_len_i,
   input  logic [MAX_KEY_BITS-1:0] key_i,
   output logic                    busy_o,
   output logic                    done_o,
   output logic                    err_o,
   output logic                    keys_valid_o,
   output logic [3:0]              num_rounds_o,
   input  logic                    rd_en_i,
   input  logic [3:0]              rd_round_i,
   output logic                    rd_valid_o,
   output logic [127:0]            rd_data_o
);

   localparam int         MAX_WORDS   = 4 * (MAX_KEY_BITS / 32 + 7);
   localparam int         KEY_WORDS   = MAX_KEY_BITS / 32;
   localparam int         STORE_WORDS = (MAX_WORDS < AES_MAX_WORDS) ? MAX_WORDS : AES_MAX_WORDS;
   localparam logic [3:0] KEY_WORDS_L = 4'(KEY_WORDS);

   exp_state_e  state_reg, state_next;

   // Schedule storage and the sliding window of the last Nk generated words
   // (win_reg[0] is the newest word w[i-1]).
   logic [31:0] store [STORE_WORDS];
   logic [31:0] win_reg [8];
   logic [31:0] key_words [8];

   logic [5:0]  idx_reg;
   logic [5:0]  last_idx_reg;
   logic [2:0]  phase_reg;       // (Nk - i mod Nk) mod Nk; zero on Rcon words
   logic [3:0]  nk_reg;
   logic [3:0]  nr_reg;
   logic [7:0]  rcon_reg;

   logic        kv_reg;
   logic        err_reg;
   logic [3:0]  num_rounds_reg;
   logic        rd_valid_reg;
   logic [127:0] rd_data_reg;

   logic        key_ready;
   logic        busy;
   logic        done;

   key_len_e    len_sel;
   logic [3:0]  nk_sel;
   logic [3:0]  nr_sel;
   logic        len_ok;
   logic        accept_ok;
   logic        accept_bad;
   logic        gen_last;

   logic [31:0] prev_word;
   logic [31:0] back_word;
   logic        at_rcon;
   logic        at_sub4;
   logic [31:0] sub_in;
   logic [31:0] sub_out;
   logic [31:0] temp_word;
   logic [31:0] new_word;

   logic [5:0]  rd_base;
   logic        rd_in_range;

   // Split the MSB-aligned key into words; words beyond the port width read as 0.
   for (genvar gi = 0; gi < 8; gi++) begin : g_key_words
      if (gi < KEY_WORDS) begin : g_used
         assign key_words[gi] = key_i[MAX_KEY_BITS-1-32*gi -: 32];
      end else begin : g_unused
         assign key_words[gi] = 32'h0;
      end
   end

   assign len_sel    = key_len_e'(key_len_i);
   assign nk_sel     = aes_nk(len_sel);
   assign nr_sel     = aes_nr(len_sel);
   assign len_ok     = (len_sel != KEY_BAD) && (nk_sel <= KEY_WORDS_L);
   assign accept_ok  = key_valid_i && key_ready && len_ok;
   assign accept_bad = key_valid_i && key_ready && !len_ok;
   assign gen_last   = (idx_reg == last_idx_reg);

   // Next-word datapath: pick w[i-1] and w[i-Nk], apply the round transform.
   always_comb begin
      prev_word = win_reg[0];
      case (nk_reg)
         4'd4:    back_word = win_reg[3];
         4'd6:    back_word = win_reg[5];
         default: back_word = win_reg[7];
      endcase
      at_rcon   = (phase_reg == 3'd0);
      at_sub4   = (nk_reg == 4'd8) && (phase_reg == 3'd4);
      sub_in    = at_rcon ? {prev_word[23:0], prev_word[31:24]} : prev_word;
      temp_word = prev_word;
      if (at_rcon) begin
         temp_word = sub_out ^ {rcon_reg, 24'h0};
      end else if (at_sub4) begin
         temp_word = sub_out;
      end
      new_word = back_word ^ temp_word;
   end

   aes_subword u_subword (
      .word_in  (sub_in),
      .word_out (sub_out)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg <= ST_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next-state logic and status outputs.
   always_comb begin
      state_next = state_reg;
      key_ready  = 1'b0;
      busy       = 1'b0;
      done       = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            key_ready = 1'b1;
            if (key_valid_i && len_ok) begin
               state_next = ST_GEN;
            end
         end
         ST_GEN: begin
            busy = 1'b1;
            if (gen_last) begin
               state_next = ST_DONE;
            end
         end
         ST_DONE: begin
            done       = 1'b1;
            state_next = ST_IDLE;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   // Expansion counters, Rcon and the sliding word window.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         idx_reg      <= 6'd0;
         last_idx_reg <= 6'd0;
         phase_reg    <= 3'd0;
         nk_reg       <= 4'd4;
         nr_reg       <= 4'd0;
         rcon_reg     <= 8'h01;
      end else if (accept_ok) begin
         idx_reg      <= {2'b00, nk_sel};
         last_idx_reg <= {nr_sel, 2'b11};
         phase_reg    <= 3'd0;
         nk_reg       <= nk_sel;
         nr_reg       <= nr_sel;
         rcon_reg     <= 8'h01;
         for (int k = 0; k < 8; k++) begin
            if (4'(k) < nk_sel) begin
               win_reg[k] <= key_words[3'(nk_sel - 4'(k) - 4'd1)];
            end
         end
      end else if (state_reg == ST_GEN) begin
         idx_reg   <= idx_reg + 6'd1;
         phase_reg <= at_rcon ? 3'(nk_reg - 4'd1) : phase_reg - 3'd1;
         if (at_rcon) begin
            rcon_reg <= xtime(rcon_reg);
         end
         win_reg[0] <= new_word;
         for (int k = 1; k < 8; k++) begin
            win_reg[k] <= win_reg[k-1];
         end
      end
   end

   // Word store: key words at accept, one generated word per GEN cycle. Never cleared.
   always_ff @(posedge clk) begin
      if (rst_n && accept_ok) begin
         for (int j = 0; j < 8; j++) begin
            if (4'(j) < nk_sel) begin
               store[j] <= key_words[j];
            end
         end
      end else if (rst_n && state_reg == ST_GEN) begin
         store[idx_reg] <= new_word;
      end
   end

   // Schedule validity, round count and the illegal-length pulse.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         kv_reg         <= 1'b0;
         num_rounds_reg <= 4'd0;
         err_reg        <= 1'b0;
      end else begin
         err_reg <= accept_bad;
         if (accept_ok || accept_bad) begin
            kv_reg         <= 1'b0;
            num_rounds_reg <= 4'd0;
         end else if (state_reg == ST_GEN && gen_last) begin
            kv_reg         <= 1'b1;
            num_rounds_reg <= nr_reg;
         end
      end
   end

   assign rd_base     = {rd_round_i, 2'b00};
   assign rd_in_range = (rd_round_i <= num_rounds_reg);

   // Registered round-key read; out-of-range rounds return zero, data holds when invalid.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rd_valid_reg <= 1'b0;
         rd_data_reg  <= '0;
      end else begin
         rd_valid_reg <= rd_en_i && kv_reg;
         if (rd_en_i && kv_reg) begin
            rd_data_reg <= rd_in_range ? {store[rd_base], store[rd_base + 6'd1],
                                          store[rd_base + 6'd2], store[rd_base + 6'd3]}
                                       : 128'h0;
         end
      end
   end

   assign key_ready_o  = key_ready;
   assign busy_o       = busy;
   assign done_o       = done;
   assign err_o        = err_reg;
   assign keys_valid_o = kv_reg;
   assign num_rounds_o = num_rounds_reg;
   assign rd_valid_o   = rd_valid_reg;
   assign rd_data_o    = rd_data_reg;

endmodule
